uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO, baud-rate divider, optional runtime-selectable parity and 1 or 2 stop bits. It is the next-generation replacement for the single-buffer, one-bit-per-clock UART transmitter. It sits between the host-side byte producer and the serial TxD pin, and accepts bursts of up to FIFO_DEPTH words without stalling the producer.

## Interface
- DATA_BITS, 8, data bits per frame (5–9)
- CLKS_PER_BIT, 1, clock cycles per serial bit (≥1)
- STOP_BITS, 1, stop bits per frame (1 or 2)
- FIFO_DEPTH, 4, transmit FIFO entries (power of 2, ≥2)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- transmit  input  1  write strobe; pushes TxData when full=0
- TxData  input  DATA_BITS  word to send
- parity_en  input  1  1 = append parity bit (sampled at frame start)
- parity_odd  input  1  1 = odd parity, 0 = even (sampled at frame start)
- TxD  output  1  serial line, idle high, registered
- busy  output  1  1 while a frame is on the line (state ≠ IDLE)
- full  output  1  FIFO holds FIFO_DEPTH words
- fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently queued
- overflow  output  1  one-cycle pulse when transmit=1 while full=1

## Operation
- Reset values: TxD=1, busy=0, full=0, fifo_count=0, overflow=0, FSM=IDLE, FIFO empty, bit/baud counters 0.
- Push: transmit=1 and full=0 → TxData written at tail, count+1. transmit=1 with full=1 → word dropped, overflow=1 for that cycle, FIFO unchanged. full is evaluated before any same-cycle pop; a push while full is rejected even if a pop occurs that cycle.
- Pop: FSM pops head when entering START; simultaneous push+pop leaves count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TxD=1. FIFO non-empty → pop, latch word, parity_en and parity_odd → START.
  - START: TxD=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: TxD = latched bit i, LSB first, i=0..DATA_BITS-1, each CLKS_PER_BIT cycles → PARITY if latched parity_en, else STOP.
  - PARITY: TxD = ^data (even) or ~^data (odd) for CLKS_PER_BIT cycles → STOP.
  - STOP: TxD=1 for STOP_BITS*CLKS_PER_BIT cycles; at end, FIFO non-empty → pop and go directly to START (no idle gap), else IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit counter advances on the wrap only.
- Changes to parity_en and parity_odd mid-frame have no effect until the next frame start.
- Reset mid-frame: TxD returns to 1 immediately (asynchronous), the queued words are discarded, and the FSM goes to IDLE.

## Timing
- Frame length F = (1 + DATA_BITS + parity_en + STOP_BITS) × CLKS_PER_BIT cycles.
- Latency: with the FIFO empty and FSM idle, a push at edge k makes fifo_count=1 after k. At edge k+1 the pop occurs: TxD=0, busy=1, fifo_count=0.
- busy falls at the edge ending the last stop bit when the FIFO is empty. In back-to-back frames, busy stays 1 and TxD goes 1→0 at the boundary edge.
- full and fifo_count update on the edge after the push/pop. overflow is registered and asserts on the edge after the rejected strobe.

## Test plan
- Reset check: assert reset with transmit=1 → TxD=1, busy=0, full=0, fifo_count=0, overflow=0. Release reset → idle line unchanged until the first push.
- 8N1 with CLKS_PER_BIT=4: push 8'hA5 → TxD holds 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each for exactly 4 cycles. busy is high for 40 cycles.
- Parity: parity_en=1, parity_odd=0 with 8'h07 → parity bit 1. parity_odd=1 with 8'h03 → parity bit 1. Frame length is 44 cycles. Toggling parity inputs mid-frame leaves the current frame unchanged.
- Burst and overflow: with FIFO_DEPTH=4, push 5 words on consecutive cycles. The first word starts immediately and 4 are queued → full=1 and overflow pulses on the 6th strobe if issued. All accepted words go out back-to-back with no idle cycle, in order.
- STOP_BITS=2 and DATA_BITS=7: push 7'h41 → frame is 10 bits × CLKS_PER_BIT, with two stop bits high before the next start.
- Reset mid-frame: assert reset during the DATA bit 3 with 2 words queued → TxD=1 and busy=0 immediately, fifo_count=0. No further frames are sent after release.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed from a small transmit FIFO.
// Frames are start, DATA_BITS data bits sent LSB first, an optional parity bit
// and STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clocks.
// Queued words go out back to back, with no idle gap between frames.
//
// Handshake: a word is accepted on any rising edge where transmit=1 and full=0.
// A strobe while full drops the word and raises overflow for one cycle.
// full is taken from the registered count, so it is never relieved by a pop
// in the same cycle.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          transmit,
  input  logic [DATA_BITS-1:0]          TxData,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  output logic                          TxD,
  output logic                          busy,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [PW:0]   DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_odd_q, par_odd_d;
  logic                  txd_q, txd_d;
  logic                  ovf_q, ovf_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];

  logic fifo_empty, fifo_full, push, pop, baud_wrap;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_CNT);
  assign push       = transmit & ~fifo_full;
  assign baud_wrap  = (baud_q == BAUD_LAST);

  // FIFO pointers, occupancy and the overflow pulse.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = transmit & fifo_full;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer. The head word and the parity settings are captured at
  // the pop, so input changes mid-frame only affect the next frame.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          data_d    = mem_q[rd_ptr_q];
          par_en_d  = parity_en;
          par_odd_d = parity_odd;
          state_d   = START;
        end
      end
      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      PARITY: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (!fifo_empty) begin
              pop       = 1'b1;
              data_d    = mem_q[rd_ptr_q];
              par_en_d  = parity_en;
              par_odd_d = parity_odd;
              state_d   = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the next cycle, derived from the next state so TxD is a flop.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:  txd_d = 1'b0;
      DATA: begin
        for (int i = 0; i < DATA_BITS; i++) begin
          if (bit_d == BW'(i)) txd_d = data_d[i];
        end
      end
      PARITY: txd_d = (^data_d) ^ par_odd_d;
      default: txd_d = 1'b1;
    endcase
  end

  // State, counter and line registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      txd_q     <= 1'b1;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      txd_q     <= txd_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage, written at the tail on an accepted push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= TxData;
    end
  end

  assign TxD        = txd_q;
  assign busy       = (state_q != IDLE);
  assign full       = fifo_full;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule
